fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with one outstanding memory request,
// a one-entry skid buffer for responses that land while IF/ID is frozen,
// and branch/jump redirect handling that discards in-flight responses.
// Optional feature macro: FETCH_STATS_EN builds the FetchCount/StallCount
// counters; without it both outputs are tied to zero.
// The memory acks a request no earlier than the cycle after it is issued.
// The ack cycle completes that request, so the bus may carry the next
// request in the same cycle.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rest,
  input  logic        Freze_In,
  input  logic        Jump,
  input  logic [15:0] JumpAddress,
  input  logic        brTaken,
  input  logic [15:0] BranchAddress,
  output logic        IMem_Req,
  output logic [15:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic [15:0] IMem_Data,
  output logic [15:0] MemResult_Out,
  output logic [15:0] PCPlus2_Out,
  output logic        Valid_Out,
  output logic [15:0] FetchCount,
  output logic [15:0] StallCount
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] pc_q;         // address of the next request to issue
  logic [15:0] addr_q;       // address of the outstanding request
  logic        pending_q;    // a request has been issued and not yet acked
  logic        valid_q;
  logic [15:0] data_q;
  logic [15:0] pc2_q;
  logic [15:0] skid_data_q;
  logic [15:0] skid_pc2_q;

  logic        redirect;
  logic [15:0] target;
  logic        held;
  logic        ack_hit;
  logic        issue;

  assign redirect = brTaken | Jump;
  // Branch wins over jump; bit 0 of any target is dropped.
  assign target   = (brTaken ? BranchAddress : JumpAddress) & 16'hFFFE;
  // Outstanding request still waiting for its response.
  assign held     = pending_q & ~IMem_Ack;
  assign ack_hit  = pending_q & IMem_Ack;
  // New request only in FETCH, bus free, output free or being consumed,
  // and not while a redirect makes the current PC stale.
  assign issue    = rest & ~redirect & (state_q == FETCH) & ~held
                  & (~valid_q | ~Freze_In);

  assign IMem_Req      = rest & (held | issue);
  assign IMem_Addr     = !rest ? 16'h0000 : (held ? addr_q : pc_q);
  assign MemResult_Out = data_q;
  assign PCPlus2_Out   = pc2_q;
  assign Valid_Out     = valid_q;

  // Fetch FSM: request tracking, PC, output register and skid buffer.
  always_ff @(posedge clk) begin
    if (!rest) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC & 16'hFFFE;
      addr_q      <= 16'h0000;
      pending_q   <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= 16'h0000;
      pc2_q       <= 16'h0000;
      skid_data_q <= 16'h0000;
      skid_pc2_q  <= 16'h0000;
    end else begin
      // NOTE: non-blocking assignments let every register here see the
      // pre-edge value of every other one, independent of statement order.
      pending_q <= held | issue;
      if (issue) addr_q <= pc_q;

      if (redirect) begin
        pc_q        <= target;
        valid_q     <= 1'b0;
        data_q      <= 16'h0000;
        pc2_q       <= 16'h0000;
        skid_data_q <= 16'h0000;
        skid_pc2_q  <= 16'h0000;
        state_q     <= held ? DISCARD : FETCH;
      end else begin
        if (issue) pc_q <= pc_q + 16'd2;
        case (state_q)
          FETCH: begin
            if (ack_hit) begin
              if (!valid_q || !Freze_In) begin
                data_q  <= IMem_Data;
                pc2_q   <= addr_q + 16'd2;
                valid_q <= 1'b1;
              end else begin
                skid_data_q <= IMem_Data;
                skid_pc2_q  <= addr_q + 16'd2;
                state_q     <= HOLD;
              end
            end else if (valid_q && !Freze_In) begin
              valid_q <= 1'b0;
              data_q  <= 16'h0000;
              pc2_q   <= 16'h0000;
            end
          end
          HOLD: begin
            if (!Freze_In) begin
              data_q      <= skid_data_q;
              pc2_q       <= skid_pc2_q;
              valid_q     <= 1'b1;
              skid_data_q <= 16'h0000;
              skid_pc2_q  <= 16'h0000;
              state_q     <= FETCH;
            end
          end
          DISCARD: begin
            if (ack_hit) state_q <= FETCH;
          end
          default: state_q <= FETCH;
        endcase
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] stall_cnt_q;
  logic        accept;

  // An instruction counts once it is taken into the output or skid register.
  assign accept = ~redirect & (state_q == FETCH) & ack_hit;

  // Statistics counters, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (!rest) begin
      fetch_cnt_q <= 16'h0000;
      stall_cnt_q <= 16'h0000;
    end else begin
      if (accept)             fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (valid_q && Freze_In) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign FetchCount = fetch_cnt_q;
  assign StallCount = stall_cnt_q;
`else
  assign FetchCount = 16'h0000;
  assign StallCount = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test of fetch_unit. A small memory model acks each
// request the cycle after it first sees it (data = addr ^ 16'h1234); the
// redirect and reset scenarios drive the ack by hand instead.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rest;
  logic        Freze_In;
  logic        Jump;
  logic [15:0] JumpAddress;
  logic        brTaken;
  logic [15:0] BranchAddress;
  logic        IMem_Req;
  logic [15:0] IMem_Addr;
  logic        IMem_Ack;
  logic [15:0] IMem_Data;
  logic [15:0] MemResult_Out;
  logic [15:0] PCPlus2_Out;
  logic        Valid_Out;
  logic [15:0] FetchCount;
  logic [15:0] StallCount;

  int n_vec = 0;
  int n_bad = 0;
  bit auto_mem;

`ifdef FETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rest         (rest),
    .Freze_In     (Freze_In),
    .Jump         (Jump),
    .JumpAddress  (JumpAddress),
    .brTaken      (brTaken),
    .BranchAddress(BranchAddress),
    .IMem_Req     (IMem_Req),
    .IMem_Addr    (IMem_Addr),
    .IMem_Ack     (IMem_Ack),
    .IMem_Data    (IMem_Data),
    .MemResult_Out(MemResult_Out),
    .PCPlus2_Out  (PCPlus2_Out),
    .Valid_Out    (Valid_Out),
    .FetchCount   (FetchCount),
    .StallCount   (StallCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cnt_exp(input logic [15:0] v);
    return STATS ? v : 16'h0000;
  endfunction

  // One clock: sample the request bus, take the edge, then update the model.
  task automatic tick();
    logic        r;
    logic [15:0] a;
    #1;
    r = IMem_Req;
    a = IMem_Addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      IMem_Ack  = r && !IMem_Ack;
      IMem_Data = a ^ 16'h1234;
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [15:0] d,
                           input logic [15:0] p2);
    check({tag, ".valid"}, {15'd0, Valid_Out}, {15'd0, v});
    check({tag, ".data"}, MemResult_Out, d);
    check({tag, ".pc2"}, PCPlus2_Out, p2);
  endtask

  task automatic check_req(input string tag, input logic r, input logic [15:0] a);
    #1;
    check({tag, ".req"}, {15'd0, IMem_Req}, {15'd0, r});
    if (r) check({tag, ".addr"}, IMem_Addr, a);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rest = 1'b0; Freze_In = 1'b0; Jump = 1'b0; JumpAddress = 16'h0000;
    brTaken = 1'b0; BranchAddress = 16'h0000;
    IMem_Ack = 1'b0; IMem_Data = 16'h0000; auto_mem = 1'b1;

    // Reset state.
    tick(); tick();
    check_out("rst", 1'b0, 16'h0000, 16'h0000);
    check_req("rst", 1'b0, 16'h0000);
    check("rst.fcnt", FetchCount, 16'h0000);
    check("rst.scnt", StallCount, 16'h0000);

    // First fetch from RESET_PC, 0-wait memory.
    rest = 1'b1;
    check_req("c0", 1'b1, 16'h0000);
    tick();                                        // C1: ack for 0
    check_out("c1", 1'b0, 16'h0000, 16'h0000);
    check_req("c1", 1'b1, 16'h0002);               // next request on ack cycle
    tick();                                        // C2
    check_out("c2", 1'b1, 16'h1234, 16'h0002);
    check("c2.fcnt", FetchCount, cnt_exp(16'd1));

    // Freeze for 3 cycles while the ack for 2 lands in the skid.
    Freze_In = 1'b1;
    check_req("c2f", 1'b1, 16'h0002);
    tick();                                        // C3: ack while frozen
    check_out("c3", 1'b1, 16'h1234, 16'h0002);
    check_req("c3", 1'b0, 16'h0000);
    tick();                                        // C4
    check_out("c4", 1'b1, 16'h1234, 16'h0002);
    tick();                                        // C5
    check_out("c5", 1'b1, 16'h1234, 16'h0002);
    check("c5.scnt", StallCount, cnt_exp(16'd3));
    Freze_In = 1'b0;
    tick();                                        // C6: skid on outputs
    check_out("c6", 1'b1, 16'h1236, 16'h0004);
    check("c6.fcnt", FetchCount, cnt_exp(16'd2));
    check_req("c6", 1'b1, 16'h0004);
    tick();                                        // C7: consumed, no data
    check_out("c7", 1'b0, 16'h0000, 16'h0000);
    check_req("c7", 1'b1, 16'h0006);
    tick();                                        // C8
    check_out("c8", 1'b1, 16'h1230, 16'h0006);

    // Jump while request for 6 is outstanding; ack 2 cycles later is dropped.
    auto_mem = 1'b0;
    Jump = 1'b1; JumpAddress = 16'h0040;
    check_req("c8j", 1'b1, 16'h0006);
    tick();                                        // C9: DISCARD
    Jump = 1'b0;
    check_out("c9", 1'b0, 16'h0000, 16'h0000);
    check_req("c9", 1'b1, 16'h0006);
    tick();                                        // C10
    IMem_Ack = 1'b1; IMem_Data = 16'hDEAD;
    check_out("c10", 1'b0, 16'h0000, 16'h0000);
    tick();                                        // C11
    IMem_Ack = 1'b0;
    check_out("c11", 1'b0, 16'h0000, 16'h0000);
    check_req("c11", 1'b1, 16'h0040);
    check("c11.fcnt", FetchCount, cnt_exp(16'd3));
    check("c11.scnt", StallCount, cnt_exp(16'd3));
    tick();                                        // C12

    // Branch and jump together, in the ack cycle: branch wins, data dropped.
    brTaken = 1'b1; BranchAddress = 16'h0100;
    Jump = 1'b1; JumpAddress = 16'h0200;
    IMem_Ack = 1'b1; IMem_Data = 16'hBEEF;
    tick();                                        // C13
    brTaken = 1'b0; Jump = 1'b0; IMem_Ack = 1'b0;
    check_out("c13", 1'b0, 16'h0000, 16'h0000);
    check_req("c13", 1'b1, 16'h0100);
    tick();                                        // C14

    // Jump to odd address: bit 0 ignored, then PC wraps from FFFE.
    Jump = 1'b1; JumpAddress = 16'hFFFF;
    tick();                                        // C15
    Jump = 1'b0;
    IMem_Ack = 1'b1; IMem_Data = 16'h0BAD;
    tick();                                        // C16
    IMem_Ack = 1'b0;
    check_req("c16", 1'b1, 16'hFFFE);
    tick();                                        // C17
    IMem_Ack = 1'b1; IMem_Data = 16'h5A5A;
    check_req("c17", 1'b1, 16'h0000);
    tick();                                        // C18
    IMem_Ack = 1'b0;
    check_out("c18", 1'b1, 16'h5A5A, 16'h0000);
    check("c18.fcnt", FetchCount, cnt_exp(16'd4));

    // Enter HOLD, then reset there.
    Freze_In = 1'b1;
    tick();                                        // C19
    IMem_Ack = 1'b1; IMem_Data = 16'h7777;
    tick();                                        // C20: HOLD
    IMem_Ack = 1'b0;
    check_out("c20", 1'b1, 16'h5A5A, 16'h0000);
    rest = 1'b0;
    check_req("c20r", 1'b0, 16'h0000);
    tick();                                        // C21
    check_out("c21", 1'b0, 16'h0000, 16'h0000);
    check("c21.fcnt", FetchCount, 16'h0000);
    check("c21.scnt", StallCount, 16'h0000);
    rest = 1'b1; Freze_In = 1'b0;
    check_req("c21", 1'b1, 16'h0000);
    tick();                                        // C22: request outstanding

    // Reset while a request is outstanding.
    rest = 1'b0;
    check_req("c22r", 1'b0, 16'h0000);
    tick();                                        // C23
    check_out("c23", 1'b0, 16'h0000, 16'h0000);
    rest = 1'b1;
    check_req("c23", 1'b1, 16'h0000);
    tick();                                        // C24
    IMem_Ack = 1'b1; IMem_Data = 16'h1111;
    tick();                                        // C25
    IMem_Ack = 1'b0;
    check_out("c25", 1'b1, 16'h1111, 16'h0002);
    check("c25.fcnt", FetchCount, cnt_exp(16'd1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
